if_id_stage: RTL



---
 rtl/if_id_stage.sv | 129 ++++++++++++
 1 files changed

// File: rtl/if_id_stage.sv
// if_id_stage: instruction-fetch stage with the IF/ID pipeline register.
// Holds the PC and fetches over a same-cycle req/ready handshake. It captures
// the fetched word into IF/ID, or parks it in a one-entry buffer while the
// hazard unit stalls.
//
// Handshake: imem_req is high whenever the FSM is in FETCH and reset is low.
// A transfer completes in any cycle where imem_req and imem_ready are both
// high, and imem_rdata is valid only in that cycle. The memory may hold
// imem_ready low for any number of cycles. Each such cycle is a wait state
// and is flagged on fetch_stall.
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PC_LE,
    input  logic        IFID_LE,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        fetch_stall,
    output logic        dbg_state_o
);

    localparam logic ST_FETCH = 1'b0;
    localparam logic ST_HOLD  = 1'b1;

    logic        state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] ipc4_q, ipc4_d;
    logic        valid_q, valid_d;

    logic        advance;
    logic        redirect;
    logic [31:0] pc_plus4;

    assign advance  = PC_LE & IFID_LE;
    // A branch from a stalled decode stage is not final yet, so it needs IFID_LE.
    assign redirect = branch_taken & IFID_LE;
    assign pc_plus4 = pc_q + 32'd4;

    assign imem_req    = (state_q == ST_FETCH) & ~reset;
    assign imem_addr   = pc_q;
    assign fetch_stall = imem_req & ~imem_ready;
    assign dbg_state_o = state_q;

    assign ifid_instr = instr_q;
    assign ifid_pc    = ipc_q;
    assign ifid_pc4   = ipc4_q;
    assign ifid_valid = valid_q;

    // Next-state selection: a redirect overrides every fetch/hold case.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        ipc4_d  = ipc4_q;
        valid_d = valid_q;
        if (redirect) begin
            // Any word returned this cycle and any buffered word are dropped.
            state_d = ST_FETCH;
            pc_d    = branch_target;
            instr_d = NOP;
            ipc_d   = 32'd0;
            ipc4_d  = 32'd0;
            valid_d = 1'b0;
        end else if (state_q == ST_FETCH) begin
            if (imem_ready && advance) begin
                instr_d = imem_rdata;
                ipc_d   = pc_q;
                ipc4_d  = pc_plus4;
                valid_d = 1'b1;
                pc_d    = pc_plus4;
            end else if (imem_ready) begin
                // The memory will not repeat the word, so park it until decode frees up.
                buf_d   = imem_rdata;
                state_d = ST_HOLD;
            end else if (advance) begin
                // Wait state: decode moves on, so give it a bubble that keeps the old addresses.
                instr_d = NOP;
                valid_d = 1'b0;
            end
        end else begin
            if (advance) begin
                instr_d = buf_q;
                ipc_d   = pc_q;
                ipc4_d  = pc_plus4;
                valid_d = 1'b1;
                pc_d    = pc_plus4;
                state_d = ST_FETCH;
            end
        end
    end

    // Register update; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            buf_q   <= 32'd0;
            instr_q <= NOP;
            ipc_q   <= 32'd0;
            ipc4_q  <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            ipc4_q  <= ipc4_d;
            valid_q <= valid_d;
        end
    end

endmodule
